cfg_chain_loader: RTL and testbench

CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

---
 rtl/cfg_chain_loader.sv | 218 +++++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: streams host configuration words MSB-first into a serial
// configuration chain, counting down the requested chain length.
// Optional readback of the chain's far end is enabled by defining CFG_READBACK_EN.
// Without it, rb_data/rb_valid are tied low and chain_in is ignored.
module cfg_chain_loader #(
  parameter int WORD_W = 16,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  chain_len,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              bit_out,
  output logic              cb_prgm_b,
  output logic              prgm_b,
  input  logic              chain_in,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Bits still to be shifted, including the one currently on bit_out while in SHIFT.
  logic [LEN_W-1:0]  remain_reg;
  // Bits of the current word queued behind bit_out, MSB-aligned.
  logic [WORD_W-1:0] word_reg;
  logic [CNT_W-1:0]  word_bits_reg;
  logic              bit_out_reg;
  logic              done_reg;

  logic start_ok;
  logic handshake;
  logic advance;
  logic final_shift;

  // A start only counts in IDLE and is cancelled by a simultaneous abort.
  assign start_ok    = start & ~abort & (state_reg == IDLE);
  assign handshake   = (state_reg == LOAD)  && (state_next == SHIFT);
  assign advance     = (state_reg == SHIFT) && (state_next == SHIFT);
  assign final_shift = (state_reg == SHIFT) && (state_next == FINISH);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and the state-decoded chain/host strobes.
  always_comb begin
    state_next = state_reg;
    wr_ready   = 1'b0;
    cb_prgm_b  = 1'b1;
    prgm_b     = 1'b1;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start_ok && (chain_len != '0)) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        wr_ready = 1'b1;
        prgm_b   = 1'b0;
        if (abort) begin
          state_next = IDLE;
        end else if (wr_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        cb_prgm_b = 1'b0;
        prgm_b    = 1'b0;
        if (abort) begin
          state_next = IDLE;
        end else if (remain_reg == LEN_W'(1)) begin
          // Last requested bit: any bits left in the word are dropped.
          state_next = FINISH;
        end else if (word_bits_reg == '0) begin
          state_next = LOAD;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Remaining-length counter: loaded on start, counts shifts, cleared when the session ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remain_reg <= '0;
    end else if (start_ok) begin
      remain_reg <= chain_len;
    end else if (state_next == IDLE) begin
      remain_reg <= '0;
    end else if (state_reg == SHIFT) begin
      remain_reg <= remain_reg - LEN_W'(1);
    end
  end

  // Word serializer: the MSB goes straight to bit_out on acceptance, the rest queue in word_reg.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_reg      <= '0;
      word_bits_reg <= '0;
      bit_out_reg   <= 1'b0;
    end else if (handshake) begin
      bit_out_reg   <= wr_data[WORD_W-1];
      word_reg      <= {wr_data[WORD_W-2:0], 1'b0};
      word_bits_reg <= WORD_CNT - CNT_W'(1);
    end else if (advance) begin
      bit_out_reg   <= word_reg[WORD_W-1];
      word_reg      <= {word_reg[WORD_W-2:0], 1'b0};
      word_bits_reg <= word_bits_reg - CNT_W'(1);
    end else if (state_next == IDLE && state_reg != IDLE) begin
      // bit_out keeps its last value; only the word bookkeeping is cleared.
      word_reg      <= '0;
      word_bits_reg <= '0;
    end
  end

  // Completion pulse: entering FINISH, or a zero-length start that never leaves IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= final_shift | (start_ok & (chain_len == '0));
    end
  end

  assign bit_out = bit_out_reg;
  assign done    = done_reg;

`ifdef CFG_READBACK_EN

  logic [WORD_W-1:0] rb_shift_reg;
  logic [WORD_W-1:0] rb_shift_next;
  logic [WORD_W-1:0] rb_just;
  logic [WORD_W-1:0] rb_data_reg;
  logic [CNT_W-1:0]  rb_cnt_reg;
  logic [CNT_W-1:0]  rb_cnt_next;
  logic              rb_valid_reg;

  // Next readback word with this cycle's chain_in appended, and its left-justified form.
  always_comb begin
    rb_shift_next = {rb_shift_reg[WORD_W-2:0], chain_in};
    rb_cnt_next   = rb_cnt_reg + CNT_W'(1);
    rb_just       = rb_shift_next << (WORD_CNT - rb_cnt_next);
  end

  // Readback capture: one chain_in sample per shift, publish full words and the final partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rb_shift_reg <= '0;
      rb_cnt_reg   <= '0;
      rb_data_reg  <= '0;
      rb_valid_reg <= 1'b0;
    end else begin
      rb_valid_reg <= 1'b0;
      if (start_ok) begin
        rb_shift_reg <= '0;
        rb_cnt_reg   <= '0;
      end else if (state_reg == SHIFT && !abort) begin
        if (rb_cnt_next == WORD_CNT) begin
          rb_data_reg  <= rb_shift_next;
          rb_valid_reg <= 1'b1;
          rb_shift_reg <= '0;
          rb_cnt_reg   <= '0;
        end else if (final_shift) begin
          rb_data_reg  <= rb_just;
          rb_valid_reg <= 1'b1;
          rb_shift_reg <= '0;
          rb_cnt_reg   <= '0;
        end else begin
          rb_shift_reg <= rb_shift_next;
          rb_cnt_reg   <= rb_cnt_next;
        end
      end
    end
  end

  assign rb_data  = rb_data_reg;
  assign rb_valid = rb_valid_reg;

`else

  logic unused_chain_in;

  assign unused_chain_in = chain_in;
  assign rb_data         = '0;
  assign rb_valid        = 1'b0;

`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: a bit-stream model (expected serial bits per
// session, truncated to chain_len) checked on every strobe, plus directed
// sessions with hand-computed literal expectations.
module tb_cfg_chain_loader;

  localparam int WORD_W = 16;
  localparam int LEN_W  = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [LEN_W-1:0]  chain_len = '0;
  logic [WORD_W-1:0] wr_data = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic              bit_out;
  logic              cb_prgm_b;
  logic              prgm_b;
  logic              chain_in;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;

  cfg_chain_loader #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .chain_len (chain_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .bit_out   (bit_out),
    .cb_prgm_b (cb_prgm_b),
    .prgm_b    (prgm_b),
    .chain_in  (chain_in),
    .busy      (busy),
    .done      (done),
    .rb_data   (rb_data),
    .rb_valid  (rb_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 16-stage chain model: chain_in replays bit_out 16 strobes later.
  logic [15:0] chain_model;
  always @(posedge clk or negedge reset) begin
    if (!reset) chain_model <= '0;
    else if (!cb_prgm_b) chain_model <= {chain_model[14:0], bit_out};
  end
  assign chain_in = chain_model[15];

  int total = 0;
  int bad = 0;

  // Model state.
  bit          exp_arr [0:1023];
  int          exp_limit = 0;
  int          sess_base = 0;
  int          sess_len = 0;
  int          sess_done0 = 0;
  int          pushed = 0;
  int          hs_cyc = 0;
  int          total_strobes = 0;
  int          last_strobe_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        last_bit = 1'b0;
  logic [31:0] hist = '0;
  logic [15:0] rb_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare: every strobe must carry the next expected bit.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("reset_outs", 32'({bit_out, cb_prgm_b, prgm_b, busy, done, wr_ready, rb_valid}),
              32'(7'b0110000));
        check("reset_rb_data", 32'(rb_data), 0);
        last_bit = 1'b0;
      end else begin
        if (!cb_prgm_b) begin
          check("strobe_prgm_b", 32'(prgm_b), 0);
          if (total_strobes >= exp_limit)
            check("strobe_within_len", total_strobes - sess_base + 1, exp_limit - sess_base);
          else
            check("bit_out", 32'(bit_out), 32'(exp_arr[total_strobes % 1024]));
          last_bit = bit_out;
          hist = {hist[30:0], bit_out};
          total_strobes++;
          last_strobe_cyc = cyc;
        end else begin
          check("bit_out_held", 32'(bit_out), 32'(last_bit));
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("done_prgm_b", 32'(prgm_b), 1);
        end
`ifdef CFG_READBACK_EN
        if (rb_valid) rb_q.push_back(rb_data);
`else
        check("rb_tied_low", 32'({rb_valid, rb_data}), 0);
`endif
      end
    end
  endtask

  task automatic start_sess(input int len);
    sess_base  = total_strobes;
    sess_done0 = done_cnt;
    sess_len   = len;
    pushed     = 0;
    exp_limit  = sess_base;
    chain_len  = LEN_W'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_prgm_b", 32'(prgm_b), 0);
    check("start_wr_ready", 32'(wr_ready), 1);
    check("start_cb_prgm_b", 32'(cb_prgm_b), 1);
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    int k = 0;
    int s0;
    while (!wr_ready && k < 100) begin
      tick();
      k++;
    end
    check("wr_ready_seen", 32'(wr_ready), 1);
    s0 = total_strobes;
    for (int g = 0; g < gap; g++) begin
      start = 1'b1;           // must be ignored while busy
      chain_len = LEN_W'(5);
      tick();
    end
    start = 1'b0;
    if (gap > 0) begin
      check("gap_strobes", total_strobes - s0, 0);
      check("gap_wr_ready", 32'(wr_ready), 1);
    end
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (pushed < sess_len) begin
        exp_arr[(sess_base + pushed) % 1024] = w[i];
        pushed++;
      end
    end
    exp_limit = sess_base + pushed;
    wr_data  = w;
    wr_valid = 1'b1;
    hs_cyc   = cyc;
    tick();
    wr_valid = 1'b0;
    wr_data  = 16'hDEAD;
  endtask

  task automatic wait_done(input int len, input string tag);
    int k = 0;
    while (done_cnt == sess_done0 && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_done_once"}, done_cnt - sess_done0, 1);
    check({tag, "_done_latency"}, done_cyc - last_strobe_cyc, 1);
    check({tag, "_strobes"}, total_strobes - sess_base, len);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic wait_strobes(input int n);
    int k = 0;
    while (total_strobes - sess_base < n && k < 100) begin
      tick();
      k++;
    end
    check("strobes_reached", total_strobes - sess_base, n);
  endtask

  initial begin
    int d0;
    int rb0;
    fork
      monitor();
    join_none

    // Reset values.
    reset = 1'b0;
    repeat (3) tick();
    check("rst_outs", 32'({bit_out, cb_prgm_b, prgm_b, busy, done, wr_ready}), 32'(6'b011000));
    reset = 1'b1;
    tick();

    // One word, exact length.
    start_sess(16);
    send_word(16'hA5C3, 0);
    wait_done(16, "t1");
    check("t1_bits", 32'(hist[15:0]), 32'(16'b1010010111000011));
    check("t1_consecutive", last_strobe_cyc - hs_cyc, 16);

    // Two words, second word truncated.
    start_sess(20);
    send_word(16'hFFFF, 0);
    send_word(16'h9000, 0);
    wait_done(20, "t2");
    check("t2_last4", 32'(hist[3:0]), 32'(4'b1001));
    check("t2_first16", 32'(hist[19:4]), 32'(16'hFFFF));

    // Five-cycle gap between words, start pulses during the gap ignored.
    start_sess(32);
    send_word(16'h0F0F, 0);
    send_word(16'hC3A5, 5);
    wait_done(32, "t3");
    check("t3_bits", 32'(hist), 32'h0F0FC3A5);

    // Abort after 7 of 16 bits, then a clean session.
    start_sess(16);
    send_word(16'h5A3C, 0);
    wait_strobes(6);
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_outs", 32'({busy, prgm_b, cb_prgm_b, wr_ready}), 32'(4'b0110));
    check("abort_strobes", total_strobes - sess_base, 7);
    check("abort_bits", 32'(hist[6:0]), 32'(7'b0101101));
    repeat (5) tick();
    check("abort_no_done", done_cnt - d0, 0);
    start_sess(16);
    send_word(16'h8001, 0);
    wait_done(16, "t4");
    check("t4_bits", 32'(hist[15:0]), 32'h8001);

    // Start together with abort in IDLE does nothing.
    d0 = done_cnt;
    start = 1'b1;
    abort = 1'b1;
    chain_len = LEN_W'(8);
    tick();
    check("start_abort_busy", 32'(busy), 0);
    chain_len = '0;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    check("start_abort_no_done", done_cnt - d0, 0);

    // Asynchronous reset in the middle of a shift.
    start_sess(16);
    send_word(16'hFFFF, 0);
    wait_strobes(3);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_outs", 32'({bit_out, cb_prgm_b, prgm_b, busy, done, wr_ready}),
          32'(6'b011000));
    @(posedge clk);
    tick();
    reset = 1'b1;
    tick();

    // Zero-length session.
    chain_len = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", 32'(done), 1);
    check("zero_busy_prgm", 32'({busy, prgm_b}), 32'(2'b01));
    tick();
    check("zero_done_pulse", 32'(done), 0);

`ifdef CFG_READBACK_EN
    rb0 = rb_q.size();
    start_sess(32);
    send_word(16'h1357, 0);
    send_word(16'hBEEF, 0);
    wait_done(32, "rb32");
    check("rb32_count", rb_q.size() - rb0, 2);
    if (rb_q.size() - rb0 == 2) begin
      check("rb32_first", 32'(rb_q[rb0]), 0);
      check("rb32_second", 32'(rb_q[rb0 + 1]), 32'h1357);
    end
    rb0 = rb_q.size();
    start_sess(20);
    send_word(16'h1234, 0);
    send_word(16'h5000, 0);
    wait_done(20, "rb20");
    check("rb20_count", rb_q.size() - rb0, 2);
    if (rb_q.size() - rb0 == 2) begin
      check("rb20_full", 32'(rb_q[rb0]), 32'hBEEF);
      check("rb20_partial", 32'(rb_q[rb0 + 1]), 32'h1000);
    end
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
